alu_exec: RTL and testbench

- Execute-stage ALU. Consumes the 4-bit operation code produced by the ALU control decoder and computes the result on two WIDTH-bit operands.
- Every result is registered.
- Single-cycle ops complete in 1 cycle. MUL runs an iterative shift-add multiplier and asserts busy_o, which drives the pipeline stall logic.

---
 rtl/alu_exec.sv | 202 ++++++++++++++++++++
 tb/tb_alu_exec.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// ============================================================================
// Module   : alu_exec
// Brief    : Execute-stage ALU with registered results and an iterative
//            shift-add multiplier. The ALU_EXEC_RADIX4_MUL_EN macro selects
//            radix-4 multiply (2 bits per cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             illegal_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);
`ifdef ALU_EXEC_RADIX4_MUL_EN
    localparam int ITERS = WIDTH / 2;
`else
    localparam int ITERS = WIDTH;
`endif
    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] c_LAST = CW'(ITERS - 1);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_XOR  = 4'b0001;
    localparam logic [3:0] c_OP_SLL  = 4'b0010;
    localparam logic [3:0] c_OP_ADD  = 4'b0011;
    localparam logic [3:0] c_OP_SUB  = 4'b0100;
    localparam logic [3:0] c_OP_MUL  = 4'b0101;
    localparam logic [3:0] c_OP_SRAI = 4'b0110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_mplr, w_mplr_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_zero, w_zero_nxt;
    logic             r_done, w_done_nxt;
    logic             r_illegal, w_illegal_nxt;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ill;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0] w_mcand_step;
    logic [WIDTH-1:0] w_mplr_step;

`ifdef ALU_EXEC_RADIX4_MUL_EN
    logic [WIDTH-1:0] r_mcand3, w_mcand3_nxt;
`endif

    // Single-cycle operations
    always_comb begin
        w_shamt   = b_i[SHW-1:0];
        w_alu_res = '0;
        w_alu_ill = 1'b0;
        case (ctrl_i)
            c_OP_AND:  w_alu_res = a_i & b_i;
            c_OP_XOR:  w_alu_res = a_i ^ b_i;
            c_OP_SLL:  w_alu_res = a_i << w_shamt;
            c_OP_ADD:  w_alu_res = a_i + b_i;
            c_OP_SUB:  w_alu_res = a_i - b_i;
            c_OP_SRAI: w_alu_res = $signed(a_i) >>> w_shamt;
            c_OP_MUL:  w_alu_res = '0;
            default:   w_alu_ill = 1'b1;
        endcase
    end

    // One multiplier iteration
    always_comb begin
`ifdef ALU_EXEC_RADIX4_MUL_EN
        case (r_mplr[1:0])
            2'd0:    w_partial = '0;
            2'd1:    w_partial = r_mcand;
            2'd2:    w_partial = r_mcand << 1;
            default: w_partial = r_mcand3;
        endcase
        w_mcand_step = r_mcand << 2;
        w_mplr_step  = r_mplr >> 2;
`else
        w_partial    = r_mplr[0] ? r_mcand : '0;
        w_mcand_step = r_mcand << 1;
        w_mplr_step  = r_mplr >> 1;
`endif
        w_acc_step = r_acc + w_partial;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mplr_nxt    = r_mplr;
        w_acc_nxt     = r_acc;
        w_count_nxt   = r_count;
        w_result_nxt  = r_result;
        w_zero_nxt    = r_zero;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
`ifdef ALU_EXEC_RADIX4_MUL_EN
        w_mcand3_nxt  = r_mcand3;
`endif
        // Flush wins over new requests and over the final multiply step
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (ctrl_i == c_OP_MUL) begin
                            w_state_nxt = S_MUL;
                            w_mcand_nxt = a_i;
                            w_mplr_nxt  = b_i;
                            w_acc_nxt   = '0;
                            w_count_nxt = '0;
`ifdef ALU_EXEC_RADIX4_MUL_EN
                            w_mcand3_nxt = a_i + (a_i << 1);
`endif
                        end else begin
                            w_result_nxt  = w_alu_res;
                            w_zero_nxt    = (w_alu_res == '0);
                            w_done_nxt    = 1'b1;
                            w_illegal_nxt = w_alu_ill;
                        end
                    end
                end
                S_MUL: begin
                    w_acc_nxt   = w_acc_step;
                    w_mcand_nxt = w_mcand_step;
                    w_mplr_nxt  = w_mplr_step;
                    w_count_nxt = r_count + CW'(1);
`ifdef ALU_EXEC_RADIX4_MUL_EN
                    w_mcand3_nxt = r_mcand3 << 2;
`endif
                    if (r_count == c_LAST) begin
                        w_state_nxt  = S_IDLE;
                        w_result_nxt = w_acc_step;
                        w_zero_nxt   = (w_acc_step == '0);
                        w_done_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_EXEC_RADIX4_MUL_EN
            r_mcand3  <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplr    <= w_mplr_nxt;
            r_acc     <= w_acc_nxt;
            r_count   <= w_count_nxt;
            r_result  <= w_result_nxt;
            r_zero    <= w_zero_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
`ifdef ALU_EXEC_RADIX4_MUL_EN
            r_mcand3  <= w_mcand3_nxt;
`endif
        end
    end

    assign result_o  = r_result;
    assign zero_o    = r_zero;
    assign done_o    = r_done;
    assign illegal_o = r_illegal;
    assign busy_o    = (r_state == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module   : tb_alu_exec
// Brief    : Directed self-checking bench for alu_exec with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

    localparam int W = 32;
`ifdef ALU_EXEC_RADIX4_MUL_EN
    localparam int MUL_CYC = 16;
`else
    localparam int MUL_CYC = 32;
`endif

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SRAI = 4'b0110;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic [3:0]   ctrl_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         flush_i;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         done_o;
    logic         illegal_o;
    logic         busy_o;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_exec #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ctrl_i    (ctrl_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .flush_i   (flush_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .done_o    (done_o),
        .illegal_o (illegal_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [W-1:0] res, input logic ill);
        exp_t e;
        e.res  = res;
        e.zero = (res == '0);
        e.ill  = ill;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = 1'b1;
        ctrl_i  = op;
        a_i     = a;
        b_i     = b;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, " done"}, W'(done_o), W'(1'b1));
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " result"}, result_o, e.res);
            chk({tag, " zero"}, W'(zero_o), W'(e.zero));
            chk({tag, " illegal"}, W'(illegal_o), W'(e.ill));
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!done_o && n < max_cyc) begin
            tick();
            n++;
        end
        check_done(tag);
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done_o) seen++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ctrl_i  = '0;
        a_i     = '0;
        b_i     = '0;
        flush_i = 1'b0;
        tick();
        tick();
        chk("rst result", result_o, '0);
        chk("rst zero", W'(zero_o), W'(1'b1));
        chk("rst done", W'(done_o), W'(1'b0));
        chk("rst illegal", W'(illegal_o), W'(1'b0));
        chk("rst busy", W'(busy_o), W'(1'b0));
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Nonzero result first so a later reset visibly clears it
        push(32'd18, 1'b0);
        drive(OP_ADD, 32'd9, 32'd9);
        check_done("add 9+9");

        // Reset in the middle of a multiply
        drive(OP_MUL, 32'd7, 32'd6);
        repeat (4) tick();
        chk("mul busy before rst", W'(busy_o), W'(1'b1));
        rst_i = 1'b1;
        #1;
        chk("midrst busy", W'(busy_o), W'(1'b0));
        chk("midrst result", result_o, '0);
        chk("midrst zero", W'(zero_o), W'(1'b1));
        chk("midrst done", W'(done_o), W'(1'b0));
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        count_done(40, seen);
        chk("no done after midrst", seen, 0);

        push(32'd7, 1'b0);
        drive(OP_ADD, 32'd3, 32'd4);
        check_done("add 3+4");

        // Back-to-back single-cycle ops
        push(32'd0, 1'b0);
        drive(OP_SUB, 32'd5, 32'd5);
        check_done("sub 5-5");
        push(32'hFFFF_FFFF, 1'b0);
        drive(OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        check_done("xor");
        push(32'h8000_0000, 1'b0);
        drive(OP_SLL, 32'd1, 32'd31);
        check_done("sll 1<<31");
        push(32'hF800_0000, 1'b0);
        drive(OP_SRAI, 32'h8000_0000, 32'd4);
        check_done("srai");
        push(32'h0000_00F0, 1'b0);
        drive(OP_AND, 32'hFFFF_00F0, 32'h0000_FFFF);
        check_done("and");

        // Multiply latency, ignored request while busy, accept on completion
        push(32'd42, 1'b0);
        drive(OP_MUL, 32'd7, 32'd6);
        n    = 0;
        seen = 0;
        while (busy_o && n < 100) begin
            if (n == 3) begin
                valid_i = 1'b1;
                ctrl_i  = OP_ADD;
                a_i     = 32'd100;
                b_i     = 32'd1;
            end else begin
                valid_i = 1'b0;
            end
            if (done_o) seen++;
            tick();
            n++;
        end
        valid_i = 1'b0;
        chk("mul busy cycles", n, MUL_CYC);
        chk("no done while busy", seen, 0);
        check_done("mul 7*6");
        push(32'd2, 1'b0);
        drive(OP_ADD, 32'd1, 32'd1);
        check_done("add in mul completion");
        tick();
        chk("no extra done", W'(done_o), W'(1'b0));

        push(32'hFFFF_FFFE, 1'b0);
        drive(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        wait_done("mul ffffffff*2", 100);

        // Flush at multiply iteration 10
        drive(OP_MUL, 32'd3, 32'd5);
        repeat (9) tick();
        chk("busy before flush", W'(busy_o), W'(1'b1));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush busy", W'(busy_o), W'(1'b0));
        chk("flush done", W'(done_o), W'(1'b0));
        chk("flush result", result_o, 32'hFFFF_FFFE);
        count_done(40, seen);
        chk("no done after flush", seen, 0);

        // Flush together with a request in IDLE drops the request
        valid_i = 1'b1;
        ctrl_i  = OP_ADD;
        a_i     = 32'd1;
        b_i     = 32'd2;
        flush_i = 1'b1;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush idle done", W'(done_o), W'(1'b0));
        chk("flush idle result", result_o, 32'hFFFF_FFFE);
        tick();
        chk("flush idle done later", W'(done_o), W'(1'b0));

        push(32'd0, 1'b1);
        drive(4'b1000, 32'd5, 32'd6);
        check_done("illegal 1000");
        tick();
        chk("illegal pulse ends", W'(illegal_o), W'(1'b0));
        chk("illegal done ends", W'(done_o), W'(1'b0));

        chk("scoreboard empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
